wb_arb_unit: RTL and testbench
==============================

Name: wb_arb_unit

Overview:
- Parametrised successor to the single-source writeback stage.
- Accepts retiring instructions from NUM_CH independent pipe channels, e.g. the main ME pipe and a long-latency mul/div/load pipe.
- Each channel has its own one-entry holding slot.
- An arbiter drives exactly one entry per cycle onto the single register-file write port and the debug trace port.
- Exports per-channel forwarding info to the decode stage.

Parameters:
- NUM_CH, 2, number of input channels (1..8).
- DATA_W, 32, result width.
- ADDR_W, 5, register-number width.
- PC_W, 32, PC width.
- ARB_MODE, 0, 0 = fixed priority (channel 0 highest), 1 = round-robin.
- Derived CH_BUS_W = PC_W+1+ADDR_W+DATA_W; per-channel payload packing is {pc, gr_we, dest, result}, MSB first.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  NUM_CH  channel i offers an entry
- in_allow_in  out  NUM_CH  channel i may transfer this cycle
- in_bus  in  NUM_CH*CH_BUS_W  channel i payload at slice [i*CH_BUS_W +: CH_BUS_W]
- rf_we  out  1  register-file write enable
- rf_waddr  out  ADDR_W  write address
- rf_wdata  out  DATA_W  write data
- debug_wb_pc  out  PC_W  PC of entry retired this cycle
- debug_wb_rf_we  out  4  {4{rf_we}}
- debug_wb_rf_wnum  out  ADDR_W  = rf_waddr
- debug_wb_rf_wdata  out  DATA_W  = rf_wdata
- fwd_dest  out  NUM_CH*ADDR_W  per-slot pending dest, 0 if none
- fwd_data  out  NUM_CH*DATA_W  per-slot pending result
- wb_idle  out  1  no slot valid

Behaviour:
- Slot state per channel: slot_valid[i] plus a payload register.
- Transfer into slot i happens when in_valid[i] && in_allow_in[i]. At the next edge, slot_valid[i] <= 1 and the payload is loaded.
- in_allow_in[i] = !slot_valid[i] || grant[i]. Combinational, so a granted slot reloads in the same cycle and gives zero-bubble streaming.
- Granted slot with no new transfer: slot_valid[i] <= 0 at the next edge.
- Arbiter: combinational, one-hot grant among valid slots.
  - ARB_MODE 0: lowest valid index wins.
  - ARB_MODE 1: search starts at ptr, wrapping modulo NUM_CH. On any grant to i, ptr <= (i+1) mod NUM_CH. ptr holds when nothing is granted.
- Retirement happens in the grant cycle:
  - rf_we = |grant & gr_we of the granted slot.
  - rf_waddr, rf_wdata, debug_wb_pc come from the granted slot.
- Entries with gr_we = 0 still need a grant to retire. They update debug_wb_pc with rf_we = 0.
- No valid slot: rf_we = 0, and address/data/pc outputs are 0.
- Latency: an uncontended entry writes the RF in the cycle after acceptance, matching the single-source stage.
- Worst-case wait is NUM_CH-1 cycles under round-robin. Under fixed priority, channel 0 can starve the others; the issue logic must bound this.
- Ordering:
  - Per-channel order is preserved.
  - Cross-channel write-after-write ordering to the same dest is guaranteed by the issue stage, not by this block.
- Forwarding: fwd_dest slice i = dest_i & {ADDR_W{slot_valid[i] && gr_we_i}}, and fwd_data slice i = result_i. This holds whether or not the slot is granted this cycle.
- wb_idle = ~|slot_valid.
- Reset:
  - slot_valid = 0, ptr = 0, payload registers = 0.
  - Outputs after reset: rf_we = 0, debug_wb_rf_we = 0, all in_allow_in = 1, fwd_dest = 0, wb_idle = 1.
- Reset mid-operation: pending slots are discarded without an RF write. Transfers offered in the reset cycle are ignored.
- Writes to dest 0 are passed through unchanged; the register file ignores them.
- NUM_CH = 1 behaves exactly like the single-source stage: always granted when valid, in_allow_in constantly 1.

Test Plan:
- NUM_CH=2, ARB_MODE=0; ch0 alone sends pc=0x1c000000, we=1, dest=4, result=0xdeadbeef → next cycle rf_we=1, waddr=4, wdata=0xdeadbeef, debug_wb_rf_we=4'hf, wb_idle=0; the cycle after, wb_idle=1.
- Both channels valid every cycle for 4 cycles, ARB_MODE=0 → ch0 retires each cycle. in_allow_in=2'b01 after the first fill. ch1 retires only once ch0 stops.
- Same stimulus with ARB_MODE=1 → grants alternate ch0, ch1, ch0, ch1. Each channel's PCs retire in issue order.
- ch1 slot holds we=0 entry pc=0x1c000010 → on grant debug_wb_pc=0x1c000010, rf_we=0. fwd_dest slice 1 is 0 while pending.
- ch1 pending dest=7 while ch0 wins → fwd_dest slice 1 = 7 and fwd_data slice 1 = result every cycle until ch1 is granted.
- Assert reset with both slots full → no rf_we in the cycle after, in_allow_in=all 1, wb_idle=1, ptr restarts at ch0.

Source files
------------

// File: rtl/wb_arb_unit.sv
// Multi-channel writeback stage: one holding slot per retiring pipe,
// arbitrated onto the single register-file write and trace port.
module wb_arb_unit #(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int PC_W     = 32,
  parameter int ARB_MODE = 0
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CH-1:0]                        in_valid,
  output logic [NUM_CH-1:0]                        in_allow_in,
  input  logic [NUM_CH*(PC_W+1+ADDR_W+DATA_W)-1:0] in_bus,
  output logic                                     rf_we,
  output logic [ADDR_W-1:0]                        rf_waddr,
  output logic [DATA_W-1:0]                        rf_wdata,
  output logic [PC_W-1:0]                          debug_wb_pc,
  output logic [3:0]                               debug_wb_rf_we,
  output logic [ADDR_W-1:0]                        debug_wb_rf_wnum,
  output logic [DATA_W-1:0]                        debug_wb_rf_wdata,
  output logic [NUM_CH*ADDR_W-1:0]                 fwd_dest,
  output logic [NUM_CH*DATA_W-1:0]                 fwd_data,
  output logic                                     wb_idle
);

  localparam int CH_BUS_W = PC_W + 1 + ADDR_W + DATA_W;
  localparam int PTR_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]   slot_valid;
  logic [CH_BUS_W-1:0] slot_bus [NUM_CH];

  logic [PC_W-1:0]     s_pc   [NUM_CH];
  logic [NUM_CH-1:0]   s_we;
  logic [ADDR_W-1:0]   s_dest [NUM_CH];
  logic [DATA_W-1:0]   s_res  [NUM_CH];

  logic [NUM_CH-1:0]   grant;
  logic [NUM_CH-1:0]   take;
  logic                any_grant;
  logic [PTR_W-1:0]    gnt_idx;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    ptr_nxt;

  // Split each slot payload into its fields
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      {s_pc[i], s_we[i], s_dest[i], s_res[i]} = slot_bus[i];
    end
  end

  // One-hot grant: fixed priority, or rotating start at ptr
  always_comb begin
    grant     = '0;
    gnt_idx   = '0;
    any_grant = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!any_grant && slot_valid[i] &&
          (ARB_MODE == 0 || i >= int'(ptr))) begin
        any_grant = 1'b1;
        grant[i]  = 1'b1;
        gnt_idx   = PTR_W'(i);
      end
    end
    if (ARB_MODE == 1) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!any_grant && slot_valid[i] &&
            i < int'(ptr)) begin
          any_grant = 1'b1;
          grant[i]  = 1'b1;
          gnt_idx   = PTR_W'(i);
        end
      end
    end
  end

  // Next search start is the channel after the winner
  always_comb begin
    ptr_nxt = gnt_idx + 1'b1;
    if (int'(gnt_idx) == NUM_CH - 1) begin
      ptr_nxt = '0;
    end
  end

  // A granted slot can refill in the same cycle
  assign in_allow_in = ~slot_valid | grant;
  assign take        = in_valid & in_allow_in;

  // Slot occupancy and payload capture
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        slot_bus[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (take[i]) begin
          slot_valid[i] <= 1'b1;
          slot_bus[i]   <=
            in_bus[i*CH_BUS_W +: CH_BUS_W];
        end else if (grant[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer advances only on a grant
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (any_grant) begin
      ptr <= ptr_nxt;
    end
  end

  // Retire the granted slot; zeros when nothing is granted
  always_comb begin
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    debug_wb_pc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        rf_we       = s_we[i];
        rf_waddr    = s_dest[i];
        rf_wdata    = s_res[i];
        debug_wb_pc = s_pc[i];
      end
    end
  end

  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
  assign wb_idle           = ~|slot_valid;

  // Pending results visible to decode, granted or not
  for (genvar g = 0; g < NUM_CH; g++) begin : g_fwd
    assign fwd_dest[g*ADDR_W +: ADDR_W] =
      s_dest[g] & {ADDR_W{slot_valid[g] & s_we[g]}};
    assign fwd_data[g*DATA_W +: DATA_W] = s_res[g];
  end

endmodule

// File: tb/tb_wb_arb_unit.sv
// Bench for wb_arb_unit: fixed-priority and round-robin
// instances side by side, driven from per-channel source queues.
module tb_wb_arb_unit;

  localparam int BW = 70;
  typedef logic [BW-1:0] pl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  vld     [2];
  logic [139:0] bus    [2];
  logic [1:0]  allow_o [2];
  logic        rf_we_o [2];
  logic [4:0]  waddr_o [2];
  logic [31:0] wdata_o [2];
  logic [31:0] pc_o    [2];
  logic [3:0]  dwe_o   [2];
  logic [4:0]  dnum_o  [2];
  logic [31:0] ddata_o [2];
  logic [9:0]  fd_o    [2];
  logic [63:0] fdat_o  [2];
  logic        idle_o  [2];

  int n_cmp = 0;
  int n_bad = 0;

  pl_t q [4][$];
  bit  mv   [2][2];
  pl_t mb   [2][2];
  int  mptr [2];

  wb_arb_unit #(.NUM_CH(2), .ARB_MODE(0)) u_fp (
    .clk(clk), .reset(reset),
    .in_valid(vld[0]), .in_allow_in(allow_o[0]),
    .in_bus(bus[0]),
    .rf_we(rf_we_o[0]), .rf_waddr(waddr_o[0]),
    .rf_wdata(wdata_o[0]), .debug_wb_pc(pc_o[0]),
    .debug_wb_rf_we(dwe_o[0]),
    .debug_wb_rf_wnum(dnum_o[0]),
    .debug_wb_rf_wdata(ddata_o[0]),
    .fwd_dest(fd_o[0]), .fwd_data(fdat_o[0]),
    .wb_idle(idle_o[0])
  );

  wb_arb_unit #(.NUM_CH(2), .ARB_MODE(1)) u_rr (
    .clk(clk), .reset(reset),
    .in_valid(vld[1]), .in_allow_in(allow_o[1]),
    .in_bus(bus[1]),
    .rf_we(rf_we_o[1]), .rf_waddr(waddr_o[1]),
    .rf_wdata(wdata_o[1]), .debug_wb_pc(pc_o[1]),
    .debug_wb_rf_we(dwe_o[1]),
    .debug_wb_rf_wnum(dnum_o[1]),
    .debug_wb_rf_wdata(ddata_o[1]),
    .fwd_dest(fd_o[1]), .fwd_data(fdat_o[1]),
    .wb_idle(idle_o[1])
  );

  function automatic pl_t mk(logic [31:0] pc, logic we,
                             logic [4:0] d, logic [31:0] r);
    return {pc, we, d, r};
  endfunction

  // Which channel retires this cycle (-1 = none)
  function automatic int win(int m);
    if (!mv[m][0] && !mv[m][1]) return -1;
    if (m == 0) return mv[m][0] ? 0 : 1;
    if (mv[m][mptr[m]]) return mptr[m];
    return 1 - mptr[m];
  endfunction

  task automatic drive();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 2; c++) begin
        vld[m][c] = q[m*2+c].size() > 0;
        bus[m][c*BW +: BW] =
          (q[m*2+c].size() > 0) ? q[m*2+c][0] : '0;
      end
    end
  endtask

  task automatic push(int m, int c, pl_t p);
    q[m*2+c].push_back(p);
    drive();
  endtask

  task automatic tick();
    int w;
    bit al;
    for (int m = 0; m < 2; m++) begin
      w = win(m);
      if (reset) begin
        for (int c = 0; c < 2; c++) begin
          mv[m][c] = 0;
          mb[m][c] = '0;
        end
        mptr[m] = 0;
      end else begin
        for (int c = 0; c < 2; c++) begin
          al = !mv[m][c] || (w == c);
          if (vld[m][c] && al) begin
            mv[m][c] = 1;
            mb[m][c] = bus[m][c*BW +: BW];
            void'(q[m*2+c].pop_front());
          end else if (w == c) begin
            mv[m][c] = 0;
          end
        end
        if (w >= 0) mptr[m] = (w + 1) % 2;
      end
    end
    @(posedge clk);
    @(negedge clk);
    drive();
  endtask

  task automatic drain();
    int n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() +
            q[3].size() > 0 || mv[0][0] || mv[0][1] ||
            mv[1][0] || mv[1][1]) && n < 40) begin
      tick();
      n++;
    end
    tick();
    n_cmp++;
    if (n >= 40 || !idle_o[0] || !idle_o[1]) begin
      n_bad++;
      $display("FAIL drain n=%0d idle=%b%b want idle 11",
               n, idle_o[0], idle_o[1]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive();
    tick();
    tick();
    reset = 1'b0;
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if ({rf_we_o[m], dwe_o[m], allow_o[m], fd_o[m],
           idle_o[m]} !== {1'b0, 4'h0, 2'b11, 10'h0, 1'b1}) begin
        n_bad++;
        $display("FAIL reset m=%0d we=%b dwe=%h al=%b fd=%h idle=%b want 0 0 11 0 1",
                 m, rf_we_o[m], dwe_o[m], allow_o[m],
                 fd_o[m], idle_o[m]);
      end
    end
  endtask

  task automatic test_single();
    push(0, 0, mk(32'h1c000000, 1'b1, 5'd4, 32'hdeadbeef));
    tick();
    n_cmp++;
    if ({rf_we_o[0], waddr_o[0], wdata_o[0], pc_o[0]} !==
        {1'b1, 5'd4, 32'hdeadbeef, 32'h1c000000}) begin
      n_bad++;
      $display("FAIL single_rf we=%b a=%0d d=%h pc=%h want 1 4 deadbeef 1c000000",
               rf_we_o[0], waddr_o[0], wdata_o[0], pc_o[0]);
    end
    n_cmp++;
    if ({dwe_o[0], dnum_o[0], ddata_o[0], idle_o[0]} !==
        {4'hf, 5'd4, 32'hdeadbeef, 1'b0}) begin
      n_bad++;
      $display("FAIL single_dbg dwe=%h n=%0d d=%h idle=%b want f 4 deadbeef 0",
               dwe_o[0], dnum_o[0], ddata_o[0], idle_o[0]);
    end
    tick();
    n_cmp++;
    if ({idle_o[0], rf_we_o[0], waddr_o[0], wdata_o[0],
         pc_o[0]} !== {1'b1, 1'b0, 5'd0, 32'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL single_after idle=%b we=%b a=%0d d=%h pc=%h want 1 0 0 0 0",
               idle_o[0], rf_we_o[0], waddr_o[0], wdata_o[0],
               pc_o[0]);
    end
  endtask

  task automatic test_stream();
    logic [31:0] efp, err;
    for (int k = 0; k < 4; k++) begin
      for (int m = 0; m < 2; m++) begin
        push(m, 0, mk(32'h1c000100 + 4*k, 1'b1,
                      5'(k + 1), 32'ha0 + k));
        push(m, 1, mk(32'h1c000200 + 4*k, 1'b1,
                      5'(k + 9), 32'hb0 + k));
      end
    end
    tick();
    for (int t = 0; t < 8; t++) begin
      efp = (t < 4) ? 32'h1c000100 + 4*t
                    : 32'h1c000200 + 4*(t - 4);
      err = (t % 2 == 0) ? 32'h1c000100 + 4*(t / 2)
                         : 32'h1c000200 + 4*(t / 2);
      n_cmp++;
      if ({rf_we_o[0], pc_o[0]} !== {1'b1, efp}) begin
        n_bad++;
        $display("FAIL stream_fp t=%0d we=%b pc=%h want 1 %h",
                 t, rf_we_o[0], pc_o[0], efp);
      end
      n_cmp++;
      if ({rf_we_o[1], pc_o[1]} !== {1'b1, err}) begin
        n_bad++;
        $display("FAIL stream_rr t=%0d we=%b pc=%h want 1 %h",
                 t, rf_we_o[1], pc_o[1], err);
      end
      if (t < 4) begin
        n_cmp++;
        if (allow_o[0] !== 2'b01) begin
          n_bad++;
          $display("FAIL stream_allow t=%0d got %b want 01",
                   t, allow_o[0]);
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_we0();
    push(0, 1, mk(32'h1c000010, 1'b0, 5'd9, 32'h55));
    tick();
    n_cmp++;
    if ({pc_o[0], rf_we_o[0], dwe_o[0], fd_o[0][9:5],
         idle_o[0]} !== {32'h1c000010, 1'b0, 4'h0, 5'd0,
                         1'b0}) begin
      n_bad++;
      $display("FAIL we0 pc=%h we=%b dwe=%h fd1=%0d idle=%b want 1c000010 0 0 0 0",
               pc_o[0], rf_we_o[0], dwe_o[0], fd_o[0][9:5],
               idle_o[0]);
    end
    drain();
  endtask

  task automatic test_fwd();
    for (int k = 0; k < 3; k++) begin
      push(0, 0, mk(32'h1c000300 + 4*k, 1'b1, 5'd3,
                    32'h30 + k));
    end
    push(0, 1, mk(32'h1c000400, 1'b1, 5'd7, 32'hcafe0007));
    tick();
    for (int t = 0; t < 4; t++) begin
      n_cmp++;
      if ({fd_o[0][9:5], fdat_o[0][63:32]} !==
          {5'd7, 32'hcafe0007}) begin
        n_bad++;
        $display("FAIL fwd_slot1 t=%0d dest=%0d data=%h want 7 cafe0007",
                 t, fd_o[0][9:5], fdat_o[0][63:32]);
      end
      n_cmp++;
      if (waddr_o[0] !== ((t < 3) ? 5'd3 : 5'd7)) begin
        n_bad++;
        $display("FAIL fwd_winner t=%0d waddr=%0d want %0d",
                 t, waddr_o[0], (t < 3) ? 3 : 7);
      end
      tick();
    end
    n_cmp++;
    if (fd_o[0] !== 10'h0) begin
      n_bad++;
      $display("FAIL fwd_clear got %h want 0", fd_o[0]);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int m = 0; m < 2; m++) begin
      push(m, 0, mk(32'h1c000500, 1'b1, 5'd1, 32'h1));
      push(m, 0, mk(32'h1c000504, 1'b1, 5'd2, 32'h2));
      push(m, 1, mk(32'h1c000600, 1'b1, 5'd5, 32'h5));
    end
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) q[i].delete();
    for (int m = 0; m < 2; m++) begin
      push(m, 0, mk(32'h1c000700, 1'b1, 5'd6, 32'h6));
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) q[i].delete();
    drive();
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if ({rf_we_o[m], allow_o[m], idle_o[m], fd_o[m]} !==
          {1'b0, 2'b11, 1'b1, 10'h0}) begin
        n_bad++;
        $display("FAIL rst_mid m=%0d we=%b al=%b idle=%b fd=%h want 0 11 1 0",
                 m, rf_we_o[m], allow_o[m], idle_o[m], fd_o[m]);
      end
    end
    push(1, 1, mk(32'h1c000810, 1'b1, 5'd8, 32'h8));
    push(1, 0, mk(32'h1c000800, 1'b1, 5'd8, 32'h7));
    tick();
    n_cmp++;
    if (pc_o[1] !== 32'h1c000800) begin
      n_bad++;
      $display("FAIL rst_ptr pc=%h want 1c000800", pc_o[1]);
    end
    drain();
  endtask

  task automatic test_random();
    int w;
    pl_t eb;
    logic e_we;
    logic [1:0] e_al;
    logic [9:0] e_fd;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (q[i].size() < 3 && $urandom_range(0, 99) < 45)
          push(i / 2, i % 2,
               mk($urandom, 1'($urandom), 5'($urandom),
                  $urandom));
      end
      for (int m = 0; m < 2; m++) begin
        w = win(m);
        eb = (w < 0) ? '0 : mb[m][w];
        e_we = (w >= 0) && eb[37];
        e_al = {!mv[m][1] || w == 1, !mv[m][0] || w == 0};
        e_fd[9:5] = (mv[m][1] && mb[m][1][37]) ?
                    mb[m][1][36:32] : 5'd0;
        e_fd[4:0] = (mv[m][0] && mb[m][0][37]) ?
                    mb[m][0][36:32] : 5'd0;
        n_cmp++;
        if ({rf_we_o[m], waddr_o[m], wdata_o[m], pc_o[m]} !==
            {e_we, eb[36:32], eb[31:0], eb[69:38]}) begin
          n_bad++;
          $display("FAIL rand_rf m=%0d c=%0d got %b %0d %h %h want %b %0d %h %h",
                   m, cyc, rf_we_o[m], waddr_o[m], wdata_o[m],
                   pc_o[m], e_we, eb[36:32], eb[31:0],
                   eb[69:38]);
        end
        n_cmp++;
        if ({dwe_o[m], dnum_o[m], ddata_o[m]} !==
            {{4{e_we}}, eb[36:32], eb[31:0]}) begin
          n_bad++;
          $display("FAIL rand_dbg m=%0d c=%0d got %h %0d %h",
                   m, cyc, dwe_o[m], dnum_o[m], ddata_o[m]);
        end
        n_cmp++;
        if ({allow_o[m], idle_o[m]} !==
            {e_al, !(mv[m][0] || mv[m][1])}) begin
          n_bad++;
          $display("FAIL rand_al m=%0d c=%0d got %b %b want %b %b",
                   m, cyc, allow_o[m], idle_o[m], e_al,
                   !(mv[m][0] || mv[m][1]));
        end
        n_cmp++;
        if ({fd_o[m], fdat_o[m]} !==
            {e_fd, mb[m][1][31:0], mb[m][0][31:0]}) begin
          n_bad++;
          $display("FAIL rand_fwd m=%0d c=%0d got %h %h want %h",
                   m, cyc, fd_o[m], fdat_o[m], e_fd);
        end
      end
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_we0();
    test_fwd();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
